// File: rtl/craps_pkg.sv
// Shared types for the craps engine: FSM state encoding and the come-out
// lose-sum test used when evaluating the first roll of a game.
package craps_pkg;

  typedef enum logic [2:0] {
    COME_OUT = 3'd0,
    EVAL_CO  = 3'd1,
    POINT    = 3'd2,
    EVAL_PT  = 3'd3,
    WIN      = 3'd4,
    LOSE     = 3'd5
  } state_t;

  // Craps on the come-out roll: 2, 3, or the highest possible sum.
  function automatic logic is_craps(input logic [4:0] sum, input logic [4:0] faces);
    return (sum == 5'd2) || (sum == 5'd3) || ({1'b0, sum} == {faces, 1'b0});
  endfunction

endpackage

// File: rtl/die_counter.sv
// Free-running die face counter, 1..FACES upward (DIR=1) or FACES..1 downward
// (DIR=0); it steps every cycle so a button press samples a pseudo-random face.
module die_counter #(
  parameter int FACES = 6,
  parameter bit DIR   = 1'b1,
  localparam int DIE_W = $clog2(FACES + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  output logic [DIE_W-1:0] value
);

  localparam logic [DIE_W-1:0] TOP   = DIE_W'(FACES);
  localparam logic [DIE_W-1:0] ONE   = DIE_W'(1);
  localparam logic [DIE_W-1:0] START = DIR ? ONE : TOP;

  logic [DIE_W-1:0] r_value;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_value <= START;
    end else if (DIR) begin
      r_value <= (r_value == TOP) ? ONE : r_value + ONE;
    end else begin
      r_value <= (r_value == ONE) ? TOP : r_value - ONE;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/craps_engine_p.sv
// Two-die craps controller: edge-detected roll buttons capture die faces, then
// a one-cycle evaluation applies come-out or point rules with an optional roll limit.
module craps_engine_p
  import craps_pkg::*;
#(
  parameter int FACES        = 6,
  parameter int NATURAL      = 7,
  parameter int YO           = 11,
  parameter int MAX_PT_ROLLS = 0,
  localparam int DIE_W = $clog2(FACES + 1),
  localparam int SUM_W = $clog2(2 * FACES + 1),
  localparam int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             Rb1,
  input  logic             Rb2,
  input  logic             play_again,
  output logic [DIE_W-1:0] DiceOut1,
  output logic [DIE_W-1:0] DiceOut2,
  output logic [SUM_W-1:0] point,
  output logic [CNT_W-1:0] roll_cnt,
  output logic             Roll,
  output logic             Win,
  output logic             Lose
);

  state_t           r_state, w_next;
  logic [DIE_W-1:0] w_die1, w_die2;
  logic [DIE_W-1:0] r_dice1, r_dice2;
  logic [SUM_W-1:0] r_point, w_sum;
  logic [CNT_W-1:0] r_roll_cnt, r_pt_rolls;
  logic             r_rb1_q, r_rb2_q, r_got1, r_got2;
  logic             r_roll, r_win, r_lose;
  logic             w_roll_n, w_win_n, w_lose_n;
  logic             w_rolling, w_press1, w_press2, w_cap1, w_cap2, w_both, w_restart;

  die_counter #(.FACES(FACES), .DIR(1'b1)) u_die1 (.CLK(CLK), .reset(reset), .value(w_die1));
  die_counter #(.FACES(FACES), .DIR(1'b0)) u_die2 (.CLK(CLK), .reset(reset), .value(w_die2));

  // A roll completes on the cycle the second die is captured (or both at once).
  assign w_rolling = (r_state == COME_OUT) || (r_state == POINT);
  assign w_press1  = Rb1 & ~r_rb1_q;
  assign w_press2  = Rb2 & ~r_rb2_q;
  assign w_cap1    = w_rolling & w_press1 & ~r_got1;
  assign w_cap2    = w_rolling & w_press2 & ~r_got2;
  assign w_both    = w_rolling & (r_got1 | w_press1) & (r_got2 | w_press2);
  assign w_restart = ((r_state == WIN) || (r_state == LOSE)) & play_again;
  assign w_sum     = SUM_W'(r_dice1) + SUM_W'(r_dice2);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= COME_OUT;
      r_roll  <= 1'b1;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_roll  <= w_roll_n;
      r_win   <= w_win_n;
      r_lose  <= w_lose_n;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      COME_OUT: if (w_both) w_next = EVAL_CO;
      POINT:    if (w_both) w_next = EVAL_PT;
      // Win test first so a YO that equals a craps sum still wins.
      EVAL_CO: begin
        if ((w_sum == SUM_W'(NATURAL)) || (w_sum == SUM_W'(YO))) w_next = WIN;
        else if (is_craps(5'(w_sum), 5'(FACES)))                 w_next = LOSE;
        else                                                     w_next = POINT;
      end
      EVAL_PT: begin
        if (w_sum == r_point)                 w_next = WIN;
        else if (w_sum == SUM_W'(NATURAL))    w_next = LOSE;
        else if ((MAX_PT_ROLLS != 0) && (r_pt_rolls == CNT_W'(MAX_PT_ROLLS)))
                                              w_next = LOSE;
        else                                  w_next = POINT;
      end
      WIN, LOSE: if (play_again) w_next = COME_OUT;
      default:   w_next = COME_OUT;
    endcase
  end

  always_comb begin
    w_roll_n = (w_next == COME_OUT) || (w_next == POINT);
    w_win_n  = (w_next == WIN);
    w_lose_n = (w_next == LOSE);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_rb1_q    <= 1'b0;
      r_rb2_q    <= 1'b0;
      r_got1     <= 1'b0;
      r_got2     <= 1'b0;
      r_dice1    <= '0;
      r_dice2    <= '0;
      r_point    <= '0;
      r_roll_cnt <= '0;
      r_pt_rolls <= '0;
    end else if (w_restart) begin
      r_rb1_q    <= 1'b0;
      r_rb2_q    <= 1'b0;
      r_got1     <= 1'b0;
      r_got2     <= 1'b0;
      r_dice1    <= '0;
      r_dice2    <= '0;
      r_point    <= '0;
      r_roll_cnt <= '0;
      r_pt_rolls <= '0;
    end else begin
      r_rb1_q <= Rb1;
      r_rb2_q <= Rb2;
      if (w_cap1) r_dice1 <= w_die1;
      if (w_cap2) r_dice2 <= w_die2;
      if (w_both) begin
        r_got1 <= 1'b0;
        r_got2 <= 1'b0;
        if (r_roll_cnt != '1) r_roll_cnt <= r_roll_cnt + 1'b1;
        if ((r_state == POINT) && (r_pt_rolls != '1)) r_pt_rolls <= r_pt_rolls + 1'b1;
      end else begin
        if (w_cap1) r_got1 <= 1'b1;
        if (w_cap2) r_got2 <= 1'b1;
      end
      if ((r_state == EVAL_CO) && (w_next == POINT)) begin
        r_point    <= w_sum;
        r_pt_rolls <= '0;
      end
    end
  end

  assign DiceOut1 = r_dice1;
  assign DiceOut2 = r_dice2;
  assign point    = r_point;
  assign roll_cnt = r_roll_cnt;
  assign Roll     = r_roll;
  assign Win      = r_win;
  assign Lose     = r_lose;

endmodule

// File: tb/tb_craps_engine_p.sv
// Bench for craps_engine_p: two instances (roll limit 3 and unlimited) share
// stimulus; a game-level model predicts every output, plus directed literal checks.
module tb_craps_engine_p;

  localparam int F = 6;
  localparam int PH_ROLL  = 0;
  localparam int PH_JUDGE = 1;
  localparam int PH_WON   = 2;
  localparam int PH_LOST  = 3;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic Rb1 = 1'b0, Rb2 = 1'b0, play_again = 1'b0;

  logic [2:0] o0_dice1, o0_dice2, o1_dice1, o1_dice2;
  logic [3:0] o0_point, o1_point;
  logic [7:0] o0_cnt, o1_cnt;
  logic       o0_roll, o0_win, o0_lose, o1_roll, o1_win, o1_lose;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state, one slot per instance.
  int g_tick;
  int m_max[2] = '{3, 0};
  int m_d1[2], m_d2[2], m_point[2], m_rolls[2], m_pt_rolls[2], m_phase[2];
  bit m_got1[2], m_got2[2], m_prev1[2], m_prev2[2];

  craps_engine_p #(.FACES(F), .MAX_PT_ROLLS(3)) u_dut0 (
    .CLK(CLK), .reset(reset), .Rb1(Rb1), .Rb2(Rb2), .play_again(play_again),
    .DiceOut1(o0_dice1), .DiceOut2(o0_dice2), .point(o0_point), .roll_cnt(o0_cnt),
    .Roll(o0_roll), .Win(o0_win), .Lose(o0_lose)
  );

  craps_engine_p #(.FACES(F), .MAX_PT_ROLLS(0)) u_dut1 (
    .CLK(CLK), .reset(reset), .Rb1(Rb1), .Rb2(Rb2), .play_again(play_again),
    .DiceOut1(o1_dice1), .DiceOut2(o1_dice2), .point(o1_point), .roll_cnt(o1_cnt),
    .Roll(o1_roll), .Win(o1_win), .Lose(o1_lose)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int i);
    m_d1[i] = 0; m_d2[i] = 0; m_point[i] = 0; m_rolls[i] = 0; m_pt_rolls[i] = 0;
    m_got1[i] = 0; m_got2[i] = 0; m_prev1[i] = 0; m_prev2[i] = 0;
    m_phase[i] = PH_ROLL;
  endtask

  task automatic model_step(input int i, input int c1, input int c2);
    int s;
    bit p1, p2;
    if ((m_phase[i] == PH_WON || m_phase[i] == PH_LOST) && play_again) begin
      model_clear(i);
      return;
    end
    p1 = Rb1 && !m_prev1[i];
    p2 = Rb2 && !m_prev2[i];
    m_prev1[i] = Rb1;
    m_prev2[i] = Rb2;
    s = m_d1[i] + m_d2[i];
    case (m_phase[i])
      PH_ROLL: begin
        if (p1 && !m_got1[i]) begin m_d1[i] = c1; m_got1[i] = 1; end
        if (p2 && !m_got2[i]) begin m_d2[i] = c2; m_got2[i] = 1; end
        if (m_got1[i] && m_got2[i]) begin
          m_got1[i] = 0; m_got2[i] = 0;
          if (m_rolls[i] < 255) m_rolls[i]++;
          if (m_point[i] != 0) m_pt_rolls[i]++;
          m_phase[i] = PH_JUDGE;
        end
      end
      PH_JUDGE: begin
        if (m_point[i] == 0) begin
          if (s == 7 || s == 11) m_phase[i] = PH_WON;
          else if (s == 2 || s == 3 || s == 2 * F) m_phase[i] = PH_LOST;
          else begin m_point[i] = s; m_pt_rolls[i] = 0; m_phase[i] = PH_ROLL; end
        end else begin
          if (s == m_point[i]) m_phase[i] = PH_WON;
          else if (s == 7) m_phase[i] = PH_LOST;
          else if (m_max[i] != 0 && m_pt_rolls[i] == m_max[i]) m_phase[i] = PH_LOST;
          else m_phase[i] = PH_ROLL;
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      g_tick = 0;
      for (int i = 0; i < 2; i++) model_clear(i);
    end else begin
      for (int i = 0; i < 2; i++) model_step(i, (g_tick % F) + 1, F - (g_tick % F));
      g_tick++;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (check_en) begin
      chk("d0_dice1", o0_dice1, m_d1[0]);
      chk("d0_dice2", o0_dice2, m_d2[0]);
      chk("d0_point", o0_point, m_point[0]);
      chk("d0_roll_cnt", o0_cnt, m_rolls[0]);
      chk("d0_roll", o0_roll, int'(m_phase[0] == PH_ROLL));
      chk("d0_win", o0_win, int'(m_phase[0] == PH_WON));
      chk("d0_lose", o0_lose, int'(m_phase[0] == PH_LOST));
      chk("d1_dice1", o1_dice1, m_d1[1]);
      chk("d1_dice2", o1_dice2, m_d2[1]);
      chk("d1_point", o1_point, m_point[1]);
      chk("d1_roll_cnt", o1_cnt, m_rolls[1]);
      chk("d1_roll", o1_roll, int'(m_phase[1] == PH_ROLL));
      chk("d1_win", o1_win, int'(m_phase[1] == PH_WON));
      chk("d1_lose", o1_lose, int'(m_phase[1] == PH_LOST));
    end
  end

  function automatic int die_next(input int which);
    return (which == 1) ? (g_tick % F) + 1 : F - (g_tick % F);
  endfunction

  // Wait (bounded) until the next clock edge would capture face v on the given die.
  task automatic wait_die(input int which, input int v);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (die_next(which) != v && n < 3 * F);
    chk("wait_die_timeout", die_next(which), v);
  endtask

  task automatic press(input int which, input int v);
    wait_die(which, v);
    if (which == 1) Rb1 = 1'b1; else Rb2 = 1'b1;
    @(negedge CLK);
    Rb1 = 1'b0;
    Rb2 = 1'b0;
  endtask

  task automatic roll(input int v1, input int v2);
    press(1, v1);
    press(2, v2);
  endtask

  task automatic again();
    play_again = 1'b1;
    @(negedge CLK);
    play_again = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    check_en = 1'b1;
    chk("rst_roll", o0_roll, 1);
    chk("rst_dice1", o0_dice1, 0);
    chk("rst_cnt", o0_cnt, 0);

    // Natural: 3 + 4 wins two cycles after the second press.
    roll(3, 4);
    chk("nat_roll_low", o0_roll, 0);
    chk("nat_win_early", o0_win, 0);
    @(negedge CLK);
    chk("nat_win", o0_win, 1);
    chk("nat_point", o0_point, 0);
    chk("nat_cnt", o0_cnt, 1);
    again();

    // Craps on 12; later presses are ignored; play_again clears.
    roll(6, 6);
    @(negedge CLK);
    chk("craps_lose", o0_lose, 1);
    press(1, 2);
    chk("craps_hold_dice1", o0_dice1, 6);
    again();
    chk("craps_restart_roll", o0_roll, 1);
    chk("craps_restart_dice1", o0_dice1, 0);

    // Point 4, held button captures once, then made.
    roll(2, 2);
    @(negedge CLK);
    chk("pt_point", o0_point, 4);
    wait_die(1, 1);
    Rb1 = 1'b1;
    repeat (10) @(negedge CLK);
    Rb1 = 1'b0;
    chk("hold_dice1", o0_dice1, 1);
    chk("hold_still_roll", o0_roll, 1);
    press(2, 3);
    @(negedge CLK);
    chk("pt_win", o0_win, 1);
    chk("pt_cnt", o0_cnt, 2);
    again();

    // Point 5, three misses: limited instance loses, unlimited keeps rolling.
    roll(2, 3);
    roll(1, 1);
    roll(2, 2);
    roll(3, 3);
    @(negedge CLK);
    chk("exh_lose_d0", o0_lose, 1);
    chk("exh_roll_d1", o1_roll, 1);
    chk("exh_point_d1", o1_point, 5);

    // Asynchronous reset while instance 1 sits in the point phase.
    #2 reset = 1'b1;
    #1;
    chk("arst_roll_d1", o1_roll, 1);
    chk("arst_point_d1", o1_point, 0);
    chk("arst_dice2_d1", o1_dice2, 0);
    chk("arst_lose_d0", o0_lose, 0);
    @(negedge CLK);
    reset = 1'b0;

    // Point 8, then both buttons in one cycle (always sums to 7): seven-out.
    roll(2, 6);
    wait_die(1, 3);
    Rb1 = 1'b1;
    Rb2 = 1'b1;
    @(negedge CLK);
    Rb1 = 1'b0;
    Rb2 = 1'b0;
    chk("sim_dice1", o0_dice1, 3);
    chk("sim_dice2", o0_dice2, 4);
    @(negedge CLK);
    chk("sim_lose_d0", o0_lose, 1);
    chk("sim_lose_d1", o1_lose, 1);

    // Random play with occasional restarts and resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      #2;
      Rb1 = 1'($urandom_range(0, 1));
      Rb2 = 1'($urandom_range(0, 1));
      play_again = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 499) == 0);
    end
    @(negedge CLK);
    #2;
    reset = 1'b0;
    play_again = 1'b0;
    repeat (3) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
